// File: rtl/mem_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// mem_stream_reader_pkg
// Shared types and default constants for the memory stream reader slice.
//   state_t        : top-level FSM encoding (IDLE, RUN, DRAIN, DONE)
//   DEF_ADDR_W     : default memory word-address width
//   DEF_DATA_W     : default memory / stream data width (multiple of 8)
//   DEF_FIFO_DEPTH : default output FIFO depth (power of two, >= 2)
//   PERF_W         : width of the stall performance counter
// -----------------------------------------------------------------------------
package mem_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_ADDR_W     = 18;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int PERF_W         = 32;

endpackage

// File: rtl/mem_stream_reader_fifo.sv
// -----------------------------------------------------------------------------
// mem_stream_reader_fifo
// Synchronous show-ahead FIFO. The head entry is always visible on o_pop_data;
// i_pop consumes it. Storage is not reset; only pointers and count are.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_push       : write i_push_data (ignored when full)
//   i_push_data  : entry to store
//   i_pop        : consume head entry (ignored when empty)
//   o_pop_data   : current head entry
//   o_count      : number of stored entries
//   o_full       : count == DEPTH
//   o_empty      : count == 0
// -----------------------------------------------------------------------------
module mem_stream_reader_fifo
  import mem_stream_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W + 1,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_push,
  input  logic [DATA_W-1:0]              i_push_data,
  input  logic                           i_pop,
  output logic [DATA_W-1:0]              o_pop_data,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full,
  output logic                           o_empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign w_push_ok  = i_push && !o_full;
  assign w_pop_ok   = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/mem_stream_reader.sv
// -----------------------------------------------------------------------------
// mem_stream_reader
// Avalon-MM read master for the single-port on-chip memory (read latency 1,
// no waitrequest). Reads `length` consecutive words starting at `base_addr`
// and presents them on a ready/valid stream, marking the final word with
// st_last. Reads are credit-limited so the output FIFO can never overflow,
// which lets the memory side run without any stall signalling.
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start             : begin transfer (sampled only in IDLE)
//   base_addr, length : block description, captured on accepted start
//   busy, done        : busy in RUN/DRAIN, one-cycle done pulse
//   avm_*             : Avalon-MM read master (chipselect = read strobe)
//   st_data/valid/ready/last : output stream
//   stall_cycles      : cycles with busy & st_valid & !st_ready
//
// Optional feature (macro MEM_STREAM_READER_PERF_EN): when defined,
// stall_cycles is a saturating counter cleared on reset and on each accepted
// start; when undefined it is tied to zero.
// -----------------------------------------------------------------------------
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_clken,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_last,
  output logic [PERF_W-1:0]   stall_cycles
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_cur_addr;
  logic [ADDR_W-1:0]  r_remaining;
  logic               r_rd_vld_p1;
  logic               r_rd_last_p1;

  logic               w_accept;
  logic               w_issue;
  logic               w_issue_last;
  logic               w_pop;
  logic [CNT_W:0]     w_inflight;
  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [DATA_W:0]    w_fifo_head;

  assign w_accept = (r_state == IDLE) && start;

  // Credit: words already buffered plus the one read in flight. The count is
  // the pre-pop value, so a same-cycle pop never grants an extra credit.
  assign w_inflight   = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_rd_vld_p1};
  assign w_issue      = (r_state == RUN) && (w_inflight < (CNT_W+1)'(FIFO_DEPTH));
  assign w_issue_last = w_issue && (r_remaining == ADDR_W'(1));
  assign w_pop        = st_valid && st_ready;

  always_comb begin
    w_state_nxt    = r_state;
    busy           = 1'b0;
    done           = 1'b0;
    avm_chipselect = w_issue;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = (length != '0) ? RUN : DONE;
      end
      RUN: begin
        busy = 1'b1;
        if (w_issue_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_pop && st_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // p0: issue stage (address out) -> p1: read data returns and is pushed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_remaining  <= '0;
      r_rd_vld_p1  <= 1'b0;
      r_rd_last_p1 <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_vld_p1  <= w_issue;
      r_rd_last_p1 <= w_issue_last;
      if (w_accept)     r_remaining <= length;
      else if (w_issue) r_remaining <= r_remaining - ADDR_W'(1);
    end
  end

  // Address wraps modulo 2^ADDR_W by plain overflow.
  always_ff @(posedge clk) begin
    if (w_accept)     r_cur_addr <= base_addr;
    else if (w_issue) r_cur_addr <= r_cur_addr + ADDR_W'(1);
  end

  mem_stream_reader_fifo #(
    .DATA_W (DATA_W + 1),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_rd_vld_p1),
    .i_push_data ({r_rd_last_p1, avm_readdata}),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_head),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) assert (!(r_rd_vld_p1 && w_fifo_full));
  end

  // Address and data are forced to zero when idle so the buses are quiet
  // out of reset rather than showing unreset storage.
  assign avm_address    = w_issue ? r_cur_addr : '0;
  assign avm_write      = 1'b0;
  assign avm_byteenable = '1;
  assign avm_clken      = 1'b1;
  assign st_valid       = !w_fifo_empty;
  assign st_data        = st_valid ? w_fifo_head[DATA_W-1:0] : '0;
  assign st_last        = st_valid && w_fifo_head[DATA_W];

`ifdef MEM_STREAM_READER_PERF_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  logic [PERF_W-1:0] r_stall_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_stall_cycles <= '0;
    else if (w_accept)                      r_stall_cycles <= '0;
    else if (busy && st_valid && !st_ready) r_stall_cycles <= sat_inc(r_stall_cycles);
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
`timescale 1ns/1ps
module tb_mem_stream_reader;

  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length = '0;
  logic          busy, done;
  logic [AW-1:0] avm_address;
  logic          avm_chipselect, avm_write, avm_clken;
  logic [1:0]    avm_byteenable;
  logic [DW-1:0] avm_readdata = '0;
  logic [DW-1:0] st_data;
  logic          st_valid, st_last;
  logic          st_ready = 1'b0;
  logic [31:0]   stall_cycles;

  always #5 clk = ~clk;

  mem_stream_reader dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_byteenable (avm_byteenable),
    .avm_clken      (avm_clken),
    .avm_readdata   (avm_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_last        (st_last),
    .stall_cycles   (stall_cycles)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 16'hA000 + a[15:0];
  endfunction

  // Memory: read latency 1; garbage when not selected.
  always @(posedge clk) avm_readdata <= avm_chipselect ? mem_word(avm_address) : 16'hDEAD;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Monitor state
  int            cyc_g = 0;
  int            busy_cnt, done_cnt, stall_cnt, vld_cnt, unstable;
  int            start_cyc, first_iss_cyc, last_iss_cyc, first_vld_cyc, done_cyc;
  logic [AW-1:0] iss_q[$];
  logic [DW-1:0] wd_q[$];
  logic          lt_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic clear_mon();
    busy_cnt = 0; done_cnt = 0; stall_cnt = 0; vld_cnt = 0; unstable = 0;
    start_cyc = -1; first_iss_cyc = -1; last_iss_cyc = -1; first_vld_cyc = -1; done_cyc = -1;
    iss_q.delete(); wd_q.delete(); lt_q.delete();
  endtask

  always @(negedge clk) begin
    cyc_g++;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (start && start_cyc < 0) start_cyc = cyc_g;
      if (avm_chipselect) begin
        iss_q.push_back(avm_address);
        if (first_iss_cyc < 0) first_iss_cyc = cyc_g;
        last_iss_cyc = cyc_g;
      end
      if (st_valid) begin
        vld_cnt++;
        if (first_vld_cyc < 0) first_vld_cyc = cyc_g;
      end
      if (st_valid && st_ready) begin
        wd_q.push_back(st_data);
        lt_q.push_back(st_last);
      end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc_g; end
      if (busy && st_valid && !st_ready) stall_cnt++;
      if (prev_stall && (!st_valid || st_data !== prev_data || st_last !== prev_last)) unstable++;
      prev_stall = st_valid && !st_ready;
      prev_data  = st_data;
      prev_last  = st_last;
    end
  end

  // mode 0: st_ready always 1; mode 1: st_ready pattern 1,0,0 repeating.
  task automatic run_xfer(input logic [AW-1:0] b, input logic [AW-1:0] l,
                          input int mode, input int restart_at);
    clear_mon();
    base_addr = b; length = l; start = 1'b1; st_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 18'h3_1234; length = 18'd5;
    for (int c = 0; c < 300 && done_cnt == 0; c++) begin
      st_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
      if (c == restart_at) begin start = 1'b1; base_addr = 18'h00200; length = 18'd2; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0; st_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_xfer(input string t, input logic [AW-1:0] b, input int l, input int exp_busy);
    logic [AW-1:0] ea;
    check({t, "_n_issue"}, 32'(iss_q.size()), 32'(l));
    check({t, "_n_words"}, 32'(wd_q.size()), 32'(l));
    for (int i = 0; i < l && i < iss_q.size(); i++) begin
      ea = b + AW'(i);
      check({t, "_addr"}, 32'(iss_q[i]), 32'(ea));
    end
    for (int i = 0; i < l && i < wd_q.size(); i++) begin
      ea = b + AW'(i);
      check({t, "_data"}, 32'(wd_q[i]), 32'(mem_word(ea)));
      check({t, "_last"}, 32'(lt_q[i]), 32'(i == l - 1));
    end
    check({t, "_done_pulses"}, 32'(done_cnt), 32'd1);
    if (exp_busy >= 0) check({t, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
  endtask

  initial begin
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cs", 32'(avm_chipselect), 32'd0);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_write", 32'(avm_write), 32'd0);
    check("rst_be", 32'(avm_byteenable), 32'd3);
    check("rst_clken", 32'(avm_clken), 32'd1);
    check("rst_valid", 32'(st_valid), 32'd0);
    check("rst_data", 32'(st_data), 32'd0);
    check("rst_last", 32'(st_last), 32'd0);
    check("rst_stall", stall_cycles, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic block, full-rate sink
    run_xfer(18'h00010, 18'd4, 0, -1);
    check_xfer("t1", 18'h00010, 4, 6);
    check("t1_issue_latency", 32'(first_iss_cyc - start_cyc), 32'd1);
    check("t1_issue_span", 32'(last_iss_cyc - first_iss_cyc), 32'd3);
    check("t1_valid_latency", 32'(first_vld_cyc - first_iss_cyc), 32'd2);
    check("t1_stall", stall_cycles, 32'd0);

    // Same block, backpressure 1,0,0
    run_xfer(18'h00010, 18'd4, 1, -1);
    check_xfer("t2", 18'h00010, 4, -1);
    check("t2_unstable", 32'(unstable), 32'd0);
    check("t2_stall_seen", 32'(stall_cnt > 0), 32'd1);
`ifdef MEM_STREAM_READER_PERF_EN
    check("t2_stall_cycles", stall_cycles, 32'(stall_cnt));
`else
    check("t2_stall_cycles", stall_cycles, 32'd0);
`endif

    // Zero length
    run_xfer(18'h00055, 18'd0, 0, -1);
    check_xfer("t3", 18'h00055, 0, 0);
    check("t3_done_latency", 32'(done_cyc - start_cyc), 32'd1);

    // Address wrap
    run_xfer(18'h3FFFE, 18'd4, 0, -1);
    check_xfer("t4", 18'h3FFFE, 4, 6);

    // Start re-asserted mid-transfer is ignored
    run_xfer(18'h00040, 18'd8, 0, 3);
    check_xfer("t5", 18'h00040, 8, 10);

    // Reset with 2 words buffered and 1 read pending
    clear_mon();
    base_addr = 18'h00020; length = 18'd8; st_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_pre_valid", 32'(st_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_cs", 32'(avm_chipselect), 32'd0);
    check("t6_valid", 32'(st_valid), 32'd0);
    check("t6_data", 32'(st_data), 32'd0);
    check("t6_last", 32'(st_last), 32'd0);
    check("t6_stall", stall_cycles, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_mon();
    repeat (6) @(posedge clk);
    #1;
    check("t6_post_valid_cycles", 32'(vld_cnt), 32'd0);
    check("t6_post_issues", 32'(iss_q.size()), 32'd0);
    check("t6_post_busy", 32'(busy_cnt), 32'd0);

    run_xfer(18'h00100, 18'd3, 0, -1);
    check_xfer("t7", 18'h00100, 3, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
- Avalon-MM read master that drives the project's single-port on-chip memory: 16-bit data, 18-bit word address, fixed read latency of 1, no waitrequest.
- Reads a programmed block of consecutive words and presents them on a ready/valid stream with last-word marking.
- Feeds downstream pixel/processing logic.
- Credit-limited pipelined reads plus a small output FIFO absorb backpressure without stalling the memory protocol.

Parameters:
- ADDR_W, 18, memory word-address width.
- DATA_W, 16, memory/stream data width; must be a multiple of 8.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2; minimum 3 for full throughput.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin transfer; sampled only in IDLE
- base_addr  in  ADDR_W  first word address; captured on accepted start
- length  in  ADDR_W  word count; captured on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- avm_address  out  ADDR_W  read address
- avm_chipselect  out  1  read-issue strobe
- avm_write  out  1  constant 0
- avm_byteenable  out  DATA_W/8  constant all-ones
- avm_clken  out  1  constant 1
- avm_readdata  in  DATA_W  memory data, valid 1 cycle after issue
- st_data  out  DATA_W  stream data
- st_valid  out  1  stream valid
- st_ready  in  1  downstream ready
- st_last  out  1  marks the final word of the block
- stall_cycles  out  32  perf counter; see Optional Feature

Behaviour:
- Reset values: all outputs 0 except avm_byteenable (all ones) and avm_clken (1).
- Reset clears state, FIFO, pending-read flag and counters.
- Read data returning after reset is discarded.
- State machine has four states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with length!=0 captures base_addr/length and goes to RUN.
  - start=1 with length=0 goes to DONE; no reads issued.
- RUN:
  - A read issues (avm_chipselect=1, avm_address=cur_addr) when fifo_count + pending < FIFO_DEPTH.
  - fifo_count is the pre-pop value; a pop in the same cycle is not credited.
  - Each issue increments cur_addr modulo 2^ADDR_W (wrap, no error) and decrements remaining.
  - The issue that brings remaining to 0 moves the FSM to DRAIN.
- Pending flag: set on issue, cleared the following cycle.
- Read return: avm_readdata is pushed into the FIFO in the cycle after issue, tagged last if it was the final issue.
- DRAIN: waits until the last-tagged word is handshaken (st_valid & st_ready & st_last), then goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0, next state IDLE.
- busy is 1 in RUN and DRAIN only.
- start is ignored unless in IDLE; never queued.
- Latency:
  - start accepted at edge t0 → first avm_chipselect in cycle t0+1.
  - Word pushed at edge t0+2 → st_valid=1 in cycle t0+2 at the earliest.
- Throughput: 1 word/cycle sustained while st_ready=1 and FIFO_DEPTH≥3.
- Stream rules:
  - st_data, st_valid and st_last hold stable while st_valid & !st_ready.
  - The FIFO is show-ahead; a pop occurs on st_valid & st_ready.
  - FIFO never overflows (credit guarantees it); push on a full FIFO is an assertion failure.
- Word ordering is strictly ascending address.
- Exactly length words are delivered per transfer.

Optional Feature:
- Macro: MEM_STREAM_READER_PERF_EN.
- Defined:
  - stall_cycles counts cycles with busy=1 and st_valid=1 and st_ready=0.
  - Cleared on reset and on each accepted start.
  - Saturates at 2^32-1.
- Undefined: stall_cycles is tied to 0 and no counter logic exists.

Decomposition:
- Package mem_stream_reader_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - default ADDR_W / DATA_W / FIFO_DEPTH constants
  - perf counter width constant (32)
- Sub-module mem_stream_reader_fifo:
  - synchronous show-ahead FIFO storing {last, data}
  - ports push/pop/count/full/empty
  - async active-high reset.

Test Plan:
- base=0x00010, length=4, memory holds 0xA000+addr, st_ready=1:
  - addresses 0x10..0x13 issued on 4 consecutive cycles
  - stream 0xA010..0xA013 with st_last only on 0xA013
  - done pulses once
  - busy high 6 cycles.
- Same block, st_ready toggling 1,0,0,1,…:
  - identical data order
  - FIFO count never exceeds 4
  - data held stable while stalled
  - with PERF_EN, stall_cycles equals the counted low-ready valid cycles.
- length=0 start: no chipselect; done pulses in the cycle after start; busy never rises.
- base=0x3FFFE, length=4: addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001 issued in order; 4 words delivered.
- start re-asserted mid-transfer with different base: ignored; original 8-word transfer completes unchanged.
- reset asserted while 2 words are in the FIFO and 1 read is pending:
  - outputs go to reset values immediately
  - no stale word appears after reset release
  - a fresh start delivers correct data.
